dma_bus_arbiter: RTL and testbench
==================================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting DMA masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum idle cycles of the owner (no data_valid) before forced release.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port request  input  NUM_MASTERS  per-master bus request, level, held until its transaction ends.
REQ-006 SHALL have port grants  output  NUM_MASTERS  one-hot-or-zero grant to the masters; one-cycle pulse per award.
REQ-007 SHALL have port busIn_busy  input  1  bus occupied by an external agent; no award while high.
REQ-008 SHALL have port busIn_data_valid  input  1  data beat on the bus; restarts the timeout counter.
REQ-009 SHALL have port busIn_end_transaction  input  1  end of the current burst.
REQ-010 SHALL have port busIn_error  input  1  bus error; terminates the current burst.
REQ-011 SHALL have port owner  output  3  index of the current owner; valid only while owner_valid is high.
REQ-012 SHALL have port owner_valid  output  1  high from the grant cycle through the end-of-ownership cycle.
REQ-013 SHALL have port abort  output  1  one-cycle pulse on a forced release (timeout or error).
REQ-014 SHALL have port timeout_count  output  16  saturating count of timeout releases since reset.

Function
REQ-015 SHALL implement the states IDLE, GRANT, OWNED and RELEASE.
REQ-016 IDLE: if busIn_busy is low and any request bit is set, SHALL select a winner round-robin, starting at (last_winner+1) mod NUM_MASTERS, and go to GRANT; otherwise SHALL stay in IDLE.
REQ-017 GRANT: SHALL drive grants[winner]=1 for exactly one cycle, set owner/owner_valid, clear the timeout counter and go to OWNED.
REQ-018 The award latency SHALL be 1 cycle: a request sampled in IDLE produces the grant pulse on the next cycle.
REQ-019 OWNED: SHALL count cycles and clear the count on each busIn_data_valid cycle.
REQ-020 OWNED: on busIn_end_transaction, SHALL go to RELEASE with no abort.
REQ-021 OWNED: on busIn_error, SHALL go to RELEASE and pulse abort.
REQ-022 OWNED: when the count reaches TIMEOUT_CYCLES-1 with no data_valid, SHALL go to RELEASE, pulse abort and increment timeout_count, saturating at 16'hFFFF.
REQ-023 Priority among simultaneous OWNED events SHALL be error > end_transaction > timeout; at most one increment and one abort pulse per release.
REQ-024 RELEASE: SHALL last exactly one cycle (bus turnaround), keep owner_valid high, update last_winner to owner, then return to IDLE; owner_valid SHALL deassert on the following cycle.
REQ-025 A request deasserted by the owner during OWNED SHALL NOT end ownership; only REQ-020 to REQ-022 end ownership.
REQ-026 busIn_busy SHALL be ignored outside IDLE.
REQ-027 A request bit that drops in the same cycle the IDLE decision is made SHALL still win if it was sampled high.
REQ-028 grants SHALL never have more than one bit set and SHALL be zero in every state except GRANT.
REQ-029 The round-robin pointer SHALL wrap from NUM_MASTERS-1 to 0.

Reset
REQ-030 On reset, SHALL go to IDLE with grants=0, owner=0, owner_valid=0, abort=0, timeout_count=0, last_winner=NUM_MASTERS-1 (so master 0 has first priority), and the timeout counter cleared.
REQ-031 Reset asserted mid-ownership SHALL take effect at the next edge; it SHALL produce no abort pulse and no counter increment.

Verification
REQ-032 Set request=4'b0001 after reset, then end_transaction 10 cycles after the grant -> grants=0001 for 1 cycle, owner=0, owner_valid high for 12 cycles, abort never set.
REQ-033 Hold request=4'b1111 for 8 transactions -> grants sequence 0001,0010,0100,1000,0001,... with the minimum IDLE->GRANT->OWNED->RELEASE spacing.
REQ-034 Hold request=4'b0110 with busIn_busy=1 for 5 cycles, then 0 -> no grant while busy; grants=0010 on the cycle after busy falls.
REQ-035 Grant master 2, give data_valid every 10 cycles, then stop -> no release while beats arrive; after 64 cycles with no data_valid, abort pulses, timeout_count=1 and the pointer advances.
REQ-036 Assert busIn_error and end_transaction in the same OWNED cycle -> exactly one abort pulse and one RELEASE cycle, timeout_count unchanged.
REQ-037 Assert reset 3 cycles into OWNED -> next cycle grants=0 and owner_valid=0, no abort; the next grant with all requests set goes to master 0.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Round-robin bus arbiter for DMA masters: awards one owner at a time and tracks
// ownership through a burst, with a forced release on bus error or idle timeout.
module dma_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grants,
  input  logic                   busIn_busy,
  input  logic                   busIn_data_valid,
  input  logic                   busIn_end_transaction,
  input  logic                   busIn_error,
  output logic [2:0]             owner,
  output logic                   owner_valid,
  output logic                   abort,
  output logic [15:0]            timeout_count
);

  typedef enum logic [1:0] {IDLE, GRANT, OWNED, RELEASE} state_t;

  localparam int              CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_owner;
  logic [2:0]      r_last;
  logic            r_abort;
  logic [15:0]     r_tcount;

  logic [2:0]      w_winner;
  logic [2:0]      w_pick_hi;
  logic [2:0]      w_pick_lo;
  logic            w_hit_hi;
  logic            w_award;
  logic            w_timeout;

  assign w_award   = (r_state == IDLE) && !busIn_busy && (|request);
  assign w_timeout = (r_count == TO_LAST) && !busIn_data_valid;

  // Lowest requester above the last winner, else lowest requester overall
  // (this is the wrap back to master 0).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_hit_hi  = 1'b0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (request[i]) begin
        if (i > int'(r_last)) begin
          w_hit_hi  = 1'b1;
          w_pick_hi = 3'(i);
        end else begin
          w_pick_lo = 3'(i);
        end
      end
    end
    w_winner = w_hit_hi ? w_pick_hi : w_pick_lo;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    grants      = '0;
    owner_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_award) w_next = GRANT;
      end
      GRANT: begin
        owner_valid = 1'b1;
        w_next      = OWNED;
        for (int i = 0; i < NUM_MASTERS; i++) grants[i] = (int'(r_owner) == i);
      end
      OWNED: begin
        owner_valid = 1'b1;
        if (busIn_error || busIn_end_transaction || w_timeout) w_next = RELEASE;
      end
      RELEASE: begin
        owner_valid = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Abort and the timeout tally are decided on the OWNED->RELEASE edge, so each
  // release yields at most one pulse and one increment; error outranks the rest.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner  <= '0;
      r_last   <= 3'(NUM_MASTERS - 1);
      r_count  <= '0;
      r_abort  <= 1'b0;
      r_tcount <= '0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE:  if (w_award) r_owner <= w_winner;
        GRANT: r_count <= '0;
        OWNED: begin
          if (busIn_data_valid)      r_count <= '0;
          else if (r_count != TO_LAST) r_count <= r_count + CW'(1);
          r_abort <= busIn_error || (!busIn_end_transaction && w_timeout);
          if (!busIn_error && !busIn_end_transaction && w_timeout && (r_tcount != 16'hFFFF))
            r_tcount <= r_tcount + 16'd1;
        end
        RELEASE: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign owner         = r_owner;
  assign abort         = r_abort;
  assign timeout_count = r_tcount;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scenario bench for dma_bus_arbiter: expected awards are queued as stimulus is
// driven and matched by a grant monitor; each scenario also checks its own results.
`timescale 1ns/1ps
module tb_dma_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  request = '0;
  logic          busy = 1'b0, dv = 1'b0, eot = 1'b0, err = 1'b0;
  logic [N-1:0]  grants;
  logic [2:0]    owner;
  logic          owner_valid, abort;
  logic [15:0]   timeout_count;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [N-1:0]  exp_q[$];

  dma_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .request               (request),
    .grants                (grants),
    .busIn_busy            (busy),
    .busIn_data_valid      (dv),
    .busIn_end_transaction (eot),
    .busIn_error           (err),
    .owner                 (owner),
    .owner_valid           (owner_valid),
    .abort                 (abort),
    .timeout_count         (timeout_count)
  );

  always #5 clock = ~clock;

  // Grant monitor: every pulse must be one-hot and match the next queued award.
  always @(negedge clock) begin
    if (grants !== '0) begin
      logic [N-1:0] e;
      logic [2:0]   e_idx;
      n_cmp++;
      if ($countones(grants) != 1) begin
        n_err++; $display("FAIL grant_onehot: got %b required one-hot", grants);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL grant_unexpected: got %b required no grant", grants);
      end else begin
        e = exp_q.pop_front();
        e_idx = '0;
        for (int i = 0; i < N; i++) if (e[i]) e_idx = 3'(i);
        if (grants !== e) begin
          n_err++; $display("FAIL grant_value: got %b required %b", grants, e);
        end
        n_cmp++;
        if (owner !== e_idx || owner_valid !== 1'b1) begin
          n_err++; $display("FAIL grant_owner: got %0d/%b required %0d/1", owner, owner_valid, e_idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; request = '0; busy = 1'b0; dv = 1'b0; eot = 1'b0; err = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Bounded wait for the next grant pulse; an expired bound counts as a failure.
  task automatic wait_grant(output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (grants === '0 && waited < 10);
    if (grants === '0) begin
      n_cmp++; n_err++;
      $display("FAIL grant_wait: got no grant within %0d cycles required a grant", waited);
    end
  endtask

  // From a grant cycle: end the burst in the first OWNED cycle and return to IDLE.
  task automatic finish_txn();
    tick(); eot = 1'b1; request = '0;
    tick(); eot = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (grants !== '0 || owner !== 3'd0 || owner_valid !== 1'b0 || abort !== 1'b0 || timeout_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: got g=%b o=%0d ov=%b ab=%b tc=%0d required 0/0/0/0/0",
               grants, owner, owner_valid, abort, timeout_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int w, ov_cycles;
    bit ab;
    do_reset();
    request = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(w);
    n_cmp++;
    if (w != 1) begin n_err++; $display("FAIL single_latency: got %0d required 1", w); end
    ov_cycles = (owner_valid === 1'b1) ? 1 : 0;
    ab = abort;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 10) begin eot = 1'b1; request = '0; end
      else eot = 1'b0;
      if (owner_valid === 1'b1) ov_cycles++;
      if (abort !== 1'b0) ab = 1'b1;
    end
    n_cmp++;
    if (ov_cycles != 12) begin n_err++; $display("FAIL single_owner_valid_len: got %0d required 12", ov_cycles); end
    n_cmp++;
    if (ab) begin n_err++; $display("FAIL single_abort: got 1 required 0"); end
  endtask

  task automatic test_round_robin();
    int w, last_cyc;
    logic [N-1:0] e;
    do_reset();
    request  = 4'b1111;
    last_cyc = 0;
    for (int t = 0; t < 8; t++) begin
      e = 4'(1 << (t % 4));
      exp_q.push_back(e);
      wait_grant(w);
      n_cmp++;
      if (t == 0 && w != 1) begin n_err++; $display("FAIL rr_first_latency: got %0d required 1", w); end
      else if (t > 0 && (cyc - last_cyc) != 4) begin
        n_err++; $display("FAIL rr_spacing: got %0d required 4 (txn %0d)", cyc - last_cyc, t);
      end
      last_cyc = cyc;
      tick(); eot = 1'b1;
      if (t == 7) request = '0;
      tick(); eot = 1'b0;
    end
    tick(); tick();
  endtask

  task automatic test_busy();
    int w;
    bit quiet;
    do_reset();
    busy = 1'b1; request = 4'b0110;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (grants !== '0 || owner_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_err++; $display("FAIL busy_hold: got activity while busy required none"); end
    busy = 1'b0;
    exp_q.push_back(4'b0010);
    wait_grant(w);
    n_cmp++;
    if (w != 1) begin n_err++; $display("FAIL busy_release_latency: got %0d required 1", w); end
    tick(); busy = 1'b1; eot = 1'b1; request = '0;
    tick(); eot = 1'b0;
    n_cmp++;
    if (owner_valid !== 1'b1) begin n_err++; $display("FAIL busy_ignored_in_release: got ov=%b required 1", owner_valid); end
    tick(); busy = 1'b0;
  endtask

  task automatic test_timeout();
    int w, at;
    bit held;
    do_reset();
    request = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(w);
    held = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      dv = (k % 10 == 0);
      if (owner_valid !== 1'b1 || abort !== 1'b0) held = 1'b0;
    end
    n_cmp++;
    if (!held) begin n_err++; $display("FAIL timeout_held_with_beats: got release required none"); end
    at = 0;
    for (int j = 1; j <= 100 && at == 0; j++) begin
      tick();
      dv = 1'b0;
      if (abort === 1'b1) at = j;
    end
    request = 4'b1111;
    exp_q.push_back(4'b1000);
    n_cmp++;
    if (at != TO + 1) begin n_err++; $display("FAIL timeout_abort_cycle: got %0d required %0d", at, TO + 1); end
    n_cmp++;
    if (timeout_count !== 16'd1) begin n_err++; $display("FAIL timeout_count: got %0d required 1", timeout_count); end
    tick();
    n_cmp++;
    if (abort !== 1'b0 || owner_valid !== 1'b0) begin
      n_err++; $display("FAIL timeout_after_release: got ab=%b ov=%b required 0/0", abort, owner_valid);
    end
    wait_grant(w);
    finish_txn();
  endtask

  task automatic test_error_end();
    int w, aborts;
    bit ab;
    request = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(w);
    tick(); err = 1'b1; eot = 1'b1;
    tick(); err = 1'b0; eot = 1'b0; request = '0;
    n_cmp++;
    if (abort !== 1'b1 || owner_valid !== 1'b1) begin
      n_err++; $display("FAIL err_eot_release: got ab=%b ov=%b required 1/1", abort, owner_valid);
    end
    aborts = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (abort === 1'b1) aborts++;
      if (k == 0 && owner_valid !== 1'b0) aborts += 100;
    end
    n_cmp++;
    if (aborts != 0) begin n_err++; $display("FAIL err_eot_single_release: got extra=%0d required 0", aborts); end
    n_cmp++;
    if (timeout_count !== 16'd1) begin n_err++; $display("FAIL err_eot_tcount: got %0d required 1", timeout_count); end
    request = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(w);
    ab = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (owner_valid !== 1'b1 || abort !== 1'b0) ab = 1'b1;
      if (k == TO) begin eot = 1'b1; request = '0; end
    end
    tick(); eot = 1'b0;
    n_cmp++;
    if (ab || abort !== 1'b0 || owner_valid !== 1'b1 || timeout_count !== 16'd1) begin
      n_err++; $display("FAIL eot_beats_timeout: got early=%b ab=%b ov=%b tc=%0d required 0/0/1/1",
                        ab, abort, owner_valid, timeout_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int w;
    request = 4'b1111;
    exp_q.push_back(4'b0100);
    wait_grant(w);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (grants !== '0 || owner_valid !== 1'b0 || abort !== 1'b0 || timeout_count !== 16'd0) begin
      n_err++; $display("FAIL reset_mid: got g=%b ov=%b ab=%b tc=%0d required 0/0/0/0",
                        grants, owner_valid, abort, timeout_count);
    end
    exp_q.push_back(4'b0001);
    wait_grant(w);
    n_cmp++;
    if (grants !== 4'b0001) begin n_err++; $display("FAIL reset_mid_regrant: got %b required 0001", grants); end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_timeout();
    test_error_end();
    test_reset_mid();
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
